regbank_sb: RTL and testbench

Parametrised multi-port register file with scoreboard, for the pipelined datapath. It provides two asynchronous read ports with write-to-read forwarding, two write ports, and per-register busy bits. A reserve port lets issue logic mark a destination as pending; a write to that register retires it. It replaces the fixed 32 x 32 single-write register bank wherever a second writeback path or hazard tracking is needed.

---
 rtl/regbank_sb.sv | 70 +++++++
 tb/tb_regbank_sb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regbank_sb.sv
// regbank_sb: multi-port register file with write forwarding and a busy-bit scoreboard
module regbank_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic              busy1,
  output logic              busy2,
  input  logic              write0,
  input  logic [ADDR_W-1:0] dr0,
  input  logic [DATA_W-1:0] wrData0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] dr1,
  input  logic [DATA_W-1:0] wrData1,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvDr,
  output logic              rsvStall,
  output logic [ADDR_W:0]   busyCount
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = ZERO_REG != 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [ADDR_W:0]   cnt_q;
  logic eff0, eff1, hit10, hit11, hit20, hit21, z1, z2, rsv_busy, acc, inc, dec0, dec1;
  assign eff0 = write0 && !reset && !(ZR && dr0 == '0);
  assign eff1 = write1 && !reset && !(ZR && dr1 == '0);
  assign hit10 = eff0 && dr0 == sr1;
  assign hit11 = eff1 && dr1 == sr1;
  assign hit20 = eff0 && dr0 == sr2;
  assign hit21 = eff1 && dr1 == sr2;
  assign z1 = ZR && sr1 == '0;
  assign z2 = ZR && sr2 == '0;
  assign rdData1 = z1 ? '0 : hit11 ? wrData1 : hit10 ? wrData0 : mem[sr1];
  assign rdData2 = z2 ? '0 : hit21 ? wrData1 : hit20 ? wrData0 : mem[sr2];
  assign busy1 = !z1 && !hit11 && !hit10 && busy_q[sr1];
  assign busy2 = !z2 && !hit21 && !hit20 && busy_q[sr2];
  assign rsv_busy = busy_q[rsvDr] && !(eff0 && dr0 == rsvDr) && !(eff1 && dr1 == rsvDr);
  assign acc = rsv && !reset && !(ZR && rsvDr == '0) && !rsv_busy;
  assign rsvStall = rsv && !acc;
  assign inc = acc && !busy_q[rsvDr];
  // a register retired and re-reserved in one cycle stays busy, so it is not a decrement
  assign dec1 = eff1 && busy_q[dr1] && !(acc && rsvDr == dr1);
  assign dec0 = eff0 && busy_q[dr0] && !(acc && rsvDr == dr0) && !(eff1 && dr1 == dr0);
  assign busyCount = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      if (eff0) begin
        mem[dr0] <= wrData0;
        busy_q[dr0] <= 1'b0;
      end
      if (eff1) begin
        mem[dr1] <= wrData1;
        busy_q[dr1] <= 1'b0;
      end
      if (acc) busy_q[rsvDr] <= 1'b1;
      cnt_q <= cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec0) - (ADDR_W+1)'(dec1);
    end
  end
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: directed and random checks of regbank_sb against an array-based reference model
module tb_regbank_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, w0, w1, rsv, b1, b2, stall;
  logic [4:0]  sr1, sr2, d0, d1, rdr;
  logic [31:0] wd0, wd1, rd1, rd2;
  logic [5:0]  cnt;
  regbank_sb dut (
    .clk(clk), .reset(reset), .sr1(sr1), .sr2(sr2), .rdData1(rd1), .rdData2(rd2),
    .busy1(b1), .busy2(b2), .write0(w0), .dr0(d0), .wrData0(wd0), .write1(w1), .dr1(d1),
    .wrData1(wd1), .rsv(rsv), .rsvDr(rdr), .rsvStall(stall), .busyCount(cnt)
  );
  logic        s_reset, s_w0, s_w1, s_rsv, s_b1, s_b2, s_stall;
  logic [2:0]  s_sr1, s_sr2, s_d0, s_d1, s_rdr;
  logic [15:0] s_wd0, s_wd1, s_rd1, s_rd2;
  logic [3:0]  s_cnt;
  regbank_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_s (
    .clk(clk), .reset(s_reset), .sr1(s_sr1), .sr2(s_sr2), .rdData1(s_rd1), .rdData2(s_rd2),
    .busy1(s_b1), .busy2(s_b2), .write0(s_w0), .dr0(s_d0), .wrData0(s_wd0), .write1(s_w1),
    .dr1(s_d1), .wrData1(s_wd1), .rsv(s_rsv), .rsvDr(s_rdr), .rsvStall(s_stall), .busyCount(s_cnt)
  );
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_data [32];
  bit m_busy [32];
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic bit eff(bit w, logic [4:0] d);
    return w && !reset && d != 0;
  endfunction
  function automatic logic [31:0] m_rd(logic [4:0] s);
    if (s == 0) return 0;
    if (eff(w1, d1) && d1 == s) return wd1;
    if (eff(w0, d0) && d0 == s) return wd0;
    return m_data[s];
  endfunction
  function automatic bit m_bz(logic [4:0] s);
    if (s == 0) return 0;
    if ((eff(w1, d1) && d1 == s) || (eff(w0, d0) && d0 == s)) return 0;
    return m_busy[s];
  endfunction
  function automatic bit m_acc();
    return rsv && !reset && rdr != 0 && !m_bz(rdr);
  endfunction
  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction
  task automatic idle();
    {reset, w0, w1, rsv} = '0;
  endtask
  task automatic look(string tag);
    #1;
    chk({tag, ":rd1"}, rd1, m_rd(sr1));
    chk({tag, ":rd2"}, rd2, m_rd(sr2));
    chk({tag, ":busy1"}, 32'(b1), 32'(m_bz(sr1)));
    chk({tag, ":busy2"}, 32'(b2), 32'(m_bz(sr2)));
    chk({tag, ":stall"}, 32'(stall), 32'(rsv && !m_acc()));
  endtask
  task automatic step(string tag);
    bit acc;
    look(tag);
    acc = m_acc();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 0;
        m_busy[i] = 0;
      end
    end else begin
      if (eff(w0, d0)) begin
        m_data[d0] = wd0;
        m_busy[d0] = 0;
      end
      if (eff(w1, d1)) begin
        m_data[d1] = wd1;
        m_busy[d1] = 0;
      end
      if (acc) m_busy[rdr] = 1;
    end
    #1;
    chk({tag, ":cnt"}, 32'(cnt), 32'(m_cnt()));
  endtask
  function automatic logic [4:0] ra();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
  endfunction
  initial begin
    idle();
    {sr1, sr2, d0, d1, rdr, wd0, wd1} = '0;
    {s_reset, s_w0, s_w1, s_rsv, s_sr1, s_sr2, s_d0, s_d1, s_rdr, s_wd0, s_wd1} = '0;
    reset = 1'b1;
    s_reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 0;
      m_busy[i] = 0;
    end
    reset = 1'b0;
    s_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sr1 = 5'(i);
      sr2 = 5'(31 - i);
      look("rst_sweep");
    end
    chk("rst_cnt", 32'(cnt), 0);
    w0 = 1; d0 = 7; wd0 = 32'h11; w1 = 1; d1 = 7; wd1 = 32'h22; sr1 = 7;
    #1 chk("col_fwd", rd1, 32'h22);
    step("col");
    idle();
    #1 chk("col_stored", rd1, 32'h22);
    rsv = 1; rdr = 3; sr1 = 3;
    step("rsv3");
    #1 chk("rsv3_busy", 32'(b1), 1);
    chk("rsv3_cnt", 32'(cnt), 1);
    chk("rsv3_again_stall", 32'(stall), 1);
    step("rsv3_again");
    idle();
    w0 = 1; d0 = 3; wd0 = 32'hA5;
    #1 chk("ret3_fwd", rd1, 32'hA5);
    chk("ret3_busy", 32'(b1), 0);
    step("ret3");
    chk("ret3_cnt", 32'(cnt), 0);
    idle();
    rsv = 1; rdr = 4; sr1 = 4;
    step("rsv4");
    idle();
    w1 = 1; d1 = 4; wd1 = 32'h5; rsv = 1; rdr = 4;
    #1 chk("rr4_stall", 32'(stall), 0);
    step("rr4");
    idle();
    #1 chk("rr4_data", rd1, 32'h5);
    chk("rr4_busy", 32'(b1), 1);
    chk("rr4_cnt", 32'(cnt), 1);
    w0 = 1; d0 = 4; wd0 = 32'h6;
    step("clr4");
    idle();
    w0 = 1; d0 = 0; wd0 = 32'hFFFF; rsv = 1; rdr = 0; sr1 = 0;
    #1 chk("z_rd", rd1, 0);
    chk("z_busy", 32'(b1), 0);
    chk("z_stall", 32'(stall), 1);
    step("z");
    idle();
    #1 chk("z_rd_after", rd1, 0);
    chk("z_cnt", 32'(cnt), 0);
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      w0 = $urandom_range(0, 1); d0 = ra(); wd0 = $urandom;
      w1 = $urandom_range(0, 1); d1 = ra(); wd1 = $urandom;
      rsv = $urandom_range(0, 1); rdr = ra();
      sr1 = ra(); sr2 = ra();
      step("rand");
    end
    idle();
    s_w0 = 1; s_d0 = 0; s_wd0 = 16'hBEEF; s_sr1 = 0;
    #1 chk("s_r0_fwd", 32'(s_rd1), 32'hBEEF);
    @(posedge clk);
    #1 s_w0 = 0;
    #1 chk("s_r0_stored", 32'(s_rd1), 32'hBEEF);
    for (int i = 0; i < 8; i++) begin
      s_rsv = 1; s_rdr = 3'(i);
      #1 chk("s_rsv_stall", 32'(s_stall), 0);
      @(posedge clk);
      #1;
    end
    s_rsv = 0;
    #1 chk("s_r0_busy", 32'(s_b1), 1);
    chk("s_cnt_full", 32'(s_cnt), 8);
    s_reset = 1; s_w0 = 1; s_d0 = 5; s_wd0 = 16'h1234; s_w1 = 1; s_d1 = 2; s_wd1 = 16'h4321;
    @(posedge clk);
    #1 {s_reset, s_w0, s_w1} = '0;
    #1 chk("s_rst_cnt", 32'(s_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      s_sr1 = 3'(i);
      s_sr2 = 3'(7 - i);
      #1 chk("s_rst_rd1", 32'(s_rd1), 0);
      chk("s_rst_rd2", 32'(s_rd2), 0);
      chk("s_rst_busy", 32'({s_b1, s_b2}), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
